// File: rtl/cmos_pkg.sv
// cmos_pkg: shared state encoding, counter width and pixel-path latency for the CMOS capture block
package cmos_pkg;
  typedef enum logic {SKIP = 1'b0, ACTIVE = 1'b1} state_t;
  localparam int CNT_W = 12;
  localparam int LATENCY = 2;
endpackage

// File: rtl/rgb565_expand.sv
// rgb565_expand: RGB565 word to 8-bit channels by MSB replication
module rgb565_expand (
  input  logic [15:0] pixel,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);
  assign red   = {pixel[15:11], pixel[15:13]};
  assign green = {pixel[10:5], pixel[10:9]};
  assign blue  = {pixel[4:0], pixel[4:2]};
endmodule

// File: rtl/cmos_capture_rgb565.sv
// cmos_capture_rgb565: byte-pair RGB565 capture with frame skipping, line/frame statistics and aligned sync outputs
module cmos_capture_rgb565
  import cmos_pkg::*;
#(
  parameter int FRAME_SKIP = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmos_vsync,
  input  logic             cmos_href,
  input  logic [7:0]       cmos_data,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [7:0]       post_img_red,
  output logic [7:0]       post_img_green,
  output logic [7:0]       post_img_blue,
  output logic             frame_valid,
  output logic [CNT_W-1:0] last_line_pixels,
  output logic [CNT_W-1:0] last_frame_lines,
  output logic             odd_byte_err
);
  localparam int SKW = $clog2(FRAME_SKIP + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic             s0_vsync, s0_href, s0_vsync_d, s0_href_d, phase;
  logic [7:0]       s0_data, hi_byte, red, green, blue;
  logic [SKW-1:0]   skip_cnt;
  logic [CNT_W-1:0] pix_cnt, line_cnt, lines_closed;
  logic             frame_start, line_end, pix_done, active, line_on;
  state_t           state;
  assign frame_start = s0_vsync & ~s0_vsync_d;
  assign line_end    = s0_href_d & ~s0_href;
  assign pix_done    = s0_href & phase;
  assign active      = state == ACTIVE;
  assign line_on     = active & s0_href;
  assign frame_valid = active;
  // a line closing in the same cycle as frame start is counted into the frame being latched
  assign lines_closed = (line_end && line_cnt != CNT_MAX) ? line_cnt + 1'b1 : line_cnt;
  rgb565_expand u_expand (
    .pixel({hi_byte, s0_data}),
    .red  (red),
    .green(green),
    .blue (blue)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vsync         <= 1'b0;
      s0_href          <= 1'b0;
      s0_data          <= '0;
      s0_vsync_d       <= 1'b0;
      s0_href_d        <= 1'b0;
      phase            <= 1'b0;
      hi_byte          <= '0;
      state            <= SKIP;
      skip_cnt         <= '0;
      pix_cnt          <= '0;
      line_cnt         <= '0;
      last_line_pixels <= '0;
      last_frame_lines <= '0;
      odd_byte_err     <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_red     <= '0;
      post_img_green   <= '0;
      post_img_blue    <= '0;
    end else begin
      s0_vsync   <= cmos_vsync;
      s0_href    <= cmos_href;
      s0_data    <= cmos_data;
      s0_vsync_d <= s0_vsync;
      s0_href_d  <= s0_href;
      phase      <= s0_href & ~phase;
      if (s0_href && !phase) hi_byte <= s0_data;
      if (state == SKIP && frame_start) begin
        if (skip_cnt == SKW'(FRAME_SKIP)) state <= ACTIVE;
        else skip_cnt <= skip_cnt + 1'b1;
      end
      if (line_end) begin
        last_line_pixels <= pix_cnt;
        pix_cnt          <= '0;
      end else if (pix_done && pix_cnt != CNT_MAX) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (frame_start) begin
        last_frame_lines <= lines_closed;
        line_cnt         <= '0;
      end else begin
        line_cnt <= lines_closed;
      end
      if (line_end && phase) odd_byte_err <= 1'b1;
      post_frame_vsync <= active & s0_vsync;
      post_frame_href  <= line_on;
      post_frame_clken <= line_on & phase;
      post_img_red     <= !line_on ? 8'd0 : pix_done ? red : post_img_red;
      post_img_green   <= !line_on ? 8'd0 : pix_done ? green : post_img_green;
      post_img_blue    <= !line_on ? 8'd0 : pix_done ? blue : post_img_blue;
    end
  end
endmodule

// File: doc/cmos_capture_rgb565.md
CMOS_CAPTURE_RGB565 -- requirements
Module: cmos_capture_rgb565

Interface
REQ-001 SHALL have parameter FRAME_SKIP, default 10: number of whole frames discarded after reset for sensor settling (0 allowed).
REQ-002 SHALL have port clk  in  1  camera pixel clock; the only clock.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cmos_vsync  in  1  sensor frame sync; active-high pulse between frames.
REQ-005 SHALL have port cmos_href  in  1  sensor line valid.
REQ-006 SHALL have port cmos_data  in  8  sensor byte, RGB565, high byte first.
REQ-007 SHALL have port post_frame_vsync  out  1  aligned vsync to the next stage.
REQ-008 SHALL have port post_frame_href  out  1  aligned href to the next stage.
REQ-009 SHALL have port post_frame_clken  out  1  one-cycle pixel-valid strobe.
REQ-010 SHALL have port post_img_red  out  8  expanded red.
REQ-011 SHALL have port post_img_green  out  8  expanded green.
REQ-012 SHALL have port post_img_blue  out  8  expanded blue.
REQ-013 SHALL have port frame_valid  out  1  high once skipping is complete.
REQ-014 SHALL have port last_line_pixels  out  12  pixel count of the most recent completed line.
REQ-015 SHALL have port last_frame_lines  out  12  line count of the most recent completed frame.
REQ-016 SHALL have port odd_byte_err  out  1  sticky flag: a line ended on an unpaired byte.

Function
REQ-017 SHALL register cmos_vsync, cmos_href and cmos_data once on input (stage S0) before any use.
REQ-018 SHALL detect frame start as the S0 vsync rising edge, and line end as the S0 href falling edge.
REQ-019 SHALL implement FSM SKIP -> ACTIVE; start in SKIP; count frame starts in SKIP; enter ACTIVE on the frame start where the count equals FRAME_SKIP; with FRAME_SKIP=0, enter ACTIVE on the first frame start.
REQ-020 SHALL drive frame_valid = (state==ACTIVE); frame_valid changes only at frame start, so no partial frame is ever emitted.
REQ-021 SHALL keep a byte-phase bit: cleared while S0 href is low; toggles on every S0 byte while href is high. Phase 0 latches the high byte; phase 1 completes the pixel.
REQ-022 SHALL form the pixel as R5=hi[7:3], G6={hi[2:0],lo[7:5]}, B5=lo[4:0].
REQ-023 SHALL expand by MSB replication: red={R5,R5[4:2]}, green={G6,G6[5:4]}, blue={B5,B5[4:2]}.
REQ-024 SHALL assert post_frame_clken for exactly one cycle, two clk edges after the low byte is present on cmos_data, with RGB valid in that same cycle.
REQ-025 SHALL delay post_frame_vsync and post_frame_href by the same 2 cycles as the pixel path.
REQ-026 SHALL force post_frame_vsync, post_frame_href and post_frame_clken to 0 while frame_valid is 0.
REQ-027 SHALL drive post_img_* to 0 whenever post_frame_href is 0.
REQ-028 SHALL count completed pixels per line; at line end, latch the count into last_line_pixels, then clear it. The counter saturates at 4095.
REQ-029 SHALL count line ends per frame; at frame start, latch the count into last_frame_lines, then clear it. Counts are taken in both states; the counter saturates at 4095.
REQ-030 SHALL set odd_byte_err when a line ends with phase=1; the dangling byte is discarded. The flag is cleared only by reset.
REQ-031 SHALL, when frame start and line end occur in the same cycle, close the line first (pixel latch and line increment), then latch the frame.

Reset
REQ-032 SHALL, on rst_n low, immediately clear all outputs, the S0 registers, counters, byte phase, delay lines and odd_byte_err, and set state to SKIP.
REQ-033 SHALL, after a mid-frame reset, resume SKIP counting from zero and emit no pixel until the following qualifying frame start.

Structure
REQ-034 SHALL place state encoding, the counter width (12) and the pipeline latency (2) in shared package cmos_pkg.
REQ-035 SHALL use one sub-module, rgb565_expand, which is combinational: 16-bit input, three 8-bit outputs.

Verification
REQ-036 SHALL check skipping: FRAME_SKIP=2, 3 frames of 4 lines x 8 pixels -> no clken during frames 1-2; frame_valid rises at the frame 3 start; 32 clken pulses.
REQ-037 SHALL check unpacking: bytes 0xF8,0x00 / 0x07,0xE0 / 0x00,0x1F / 0x84,0x10 -> RGB (255,0,0), (0,255,0), (0,0,255), (132,130,132), each 2 cycles after the low byte.
REQ-038 SHALL check statistics: line of 640 pixels, frame of 480 lines -> last_line_pixels=640, last_frame_lines=480 after the next frame start.
REQ-039 SHALL check odd bytes: line of 9 bytes -> 4 clken pulses, odd_byte_err=1 and held, last_line_pixels=4.
REQ-040 SHALL check mid-frame reset: rst_n low for 3 cycles during an active line -> all outputs 0 at once, frame_valid=0, FRAME_SKIP frames skipped again.
REQ-041 SHALL check FRAME_SKIP=0: first frame after reset fully output, with post_frame_href tracking cmos_href delayed by 2 cycles.
